// File: rtl/pol_add_sub_ctrl_if.sv
// Bundle of the start/busy/done handshake, operand RAM read port, datapath
// drive/return and result RAM write port used by pol_add_sub_ctrl.
// The controller connects through the slave modport; the scheduler,
// memories and datapath side connect through master.
interface pol_add_sub_ctrl_if #(
    parameter int unsigned AW = 8
);
    logic           start;
    logic [2:0]     op;
    logic           stall;
    logic           busy;
    logic           done;
    logic           reject;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [15:0]    a_data;
    logic [15:0]    b_data;
    logic [15:0]    dp_pol_1;
    logic [15:0]    dp_pol_2;
    logic [2:0]     dp_control;
    logic           dp_enable;
    logic [15:0]    dp_out;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [15:0]    wr_data;
    logic           err;

    modport slave (
        input  start, op, stall, a_data, b_data, dp_out,
        output busy, done, reject, rd_en, rd_addr,
               dp_pol_1, dp_pol_2, dp_control, dp_enable,
               wr_en, wr_addr, wr_data, err
    );

    modport master (
        output start, op, stall, a_data, b_data, dp_out,
        input  busy, done, reject, rd_en, rd_addr,
               dp_pol_1, dp_pol_2, dp_control, dp_enable,
               wr_en, wr_addr, wr_data, err
    );
endinterface

// File: rtl/pol_add_sub_ctrl.sv
// Sequencer streaming an N-coefficient polynomial pair through the
// Pol_add_sub datapath, one coefficient per cycle, with a two-stage
// read -> datapath -> write pipeline and a start/busy/done handshake.
// Optional build macro POL_ADD_SUB_CTRL_CHECK_EN adds a sticky range
// check of the operands against MODULUS; without it err is tied low.
module pol_add_sub_ctrl #(
    parameter int unsigned N       = 256,
    parameter int unsigned AW      = 8,
    parameter logic [15:0] MODULUS = 16'h1e01
) (
    input logic               clk,
    input logic               rst,
    pol_add_sub_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    state_t         state;
    logic [AW-1:0]  cnt;
    logic [2:0]     op_q;
    logic           busy_q;
    logic           done_q;
    logic           reject_q;

    // stage 1: coefficient at the RAM outputs / datapath inputs
    logic           v1;
    logic [AW-1:0]  a1;
    // stage 2: registered datapath result at the write port
    logic           v2;
    logic [AW-1:0]  wr_addr_q;
    logic [15:0]    wr_data_q;

    logic           accept;
    logic           issue;

    assign accept = (state == S_IDLE) && bus.start && bus.op[2];
    assign issue  = (state == S_RUN) && !bus.stall;

    // Control FSM: accept/reject requests, walk the read counter, wait for drain
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            reject_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.op[2]) begin
                            op_q   <= bus.op;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= S_RUN;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!bus.stall) begin
                        cnt <= cnt + AW'(1);
                        if (cnt == LAST_IDX) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // stage 1 empty now means stage 2 holds the last write
                    if (!bus.stall && !v1) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-stage pipeline; the whole pipe freezes while stall is high
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            a1        <= '0;
            v2        <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (!bus.stall) begin
            v1        <= (state == S_RUN);
            a1        <= cnt;
            v2        <= v1;
            wr_addr_q <= a1;
            if (v1) begin
                wr_data_q <= bus.dp_out;
            end
        end
    end

`ifdef POL_ADD_SUB_CTRL_CHECK_EN
    logic err_q;

    // Sticky operand range flag, cleared by reset or the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (v1 && ((bus.a_data >= MODULUS) || (bus.b_data >= MODULUS))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_modulus;

    assign unused_modulus = ^MODULUS;
    assign bus.err        = 1'b0;
`endif

    // Strobes are masked by stall in the same cycle so a stalled beat is never
    // issued; the held beat goes out on the first cycle stall drops.
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.reject     = reject_q;
    assign bus.rd_en      = issue;
    assign bus.rd_addr    = cnt;
    assign bus.dp_enable  = v1;
    assign bus.dp_control = op_q;
    assign bus.dp_pol_1   = v1 ? bus.a_data : 16'h0000;
    assign bus.dp_pol_2   = v1 ? bus.b_data : 16'h0000;
    assign bus.wr_en      = v2 && !bus.stall;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_pol_add_sub_ctrl.sv
// Bench for pol_add_sub_ctrl: operand RAMs and a Pol_add_sub datapath
// surround the controller; every write and every handshake timing is
// compared against a coefficient-level model of the polynomial op.
module tb_pol_add_sub_ctrl;

    localparam int unsigned N  = 256;
    localparam int unsigned AW = 8;
    localparam int          Q  = 7681;
    localparam logic [16:0] Q17 = 17'd7681;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pol_add_sub_ctrl_if #(.AW(AW)) bus ();

    pol_add_sub_ctrl #(
        .N      (N),
        .AW     (AW),
        .MODULUS(16'h1e01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] mem_a [N];
    logic [15:0] mem_b [N];
    logic [16:0] dp_sum;

    int n_cmp = 0;
    int n_bad = 0;
    logic last_err_done, last_err_post, err_c1;

    // operand RAMs: registered read, outputs hold while rd_en is low
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.a_data <= mem_a[bus.rd_addr];
            bus.b_data <= mem_b[bus.rd_addr];
        end
    end

    // combinational datapath: add, or pol_2 - pol_1, modulo q
    always_comb begin
        dp_sum = 17'(bus.dp_pol_1) + 17'(bus.dp_pol_2);
        if (bus.dp_control == 3'b111) begin
            if (bus.dp_pol_2 >= bus.dp_pol_1)
                bus.dp_out = bus.dp_pol_2 - bus.dp_pol_1;
            else
                bus.dp_out = 16'(17'(bus.dp_pol_2) + Q17 - 17'(bus.dp_pol_1));
        end else if (bus.dp_control[2]) begin
            bus.dp_out = (dp_sum >= Q17) ? 16'(dp_sum - Q17) : dp_sum[15:0];
        end else begin
            bus.dp_out = 16'h0000;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference coefficient from the polynomial rule, plain integer math
    function automatic int ref_coef(input logic [2:0] opc, input int a, input int b);
        if (opc == 3'b111) return (((b - a) % Q) + Q) % Q;
        return (a + b) % Q;
    endfunction

    task automatic fill_mem(input bit rnd);
        for (int k = 0; k < int'(N); k++) begin
            mem_a[k] = rnd ? 16'($urandom_range(Q - 1)) : 16'd7000;
            mem_b[k] = rnd ? 16'($urandom_range(Q - 1)) : 16'd1000;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, 32'({bus.busy, bus.done, bus.reject, bus.rd_en, bus.wr_en,
                                     bus.dp_enable, bus.err, bus.dp_control, bus.rd_addr,
                                     bus.wr_addr}), 32'd0);
        check_eq({tag, "_data"}, {bus.wr_data, bus.dp_pol_1}, 32'd0);
        check_eq({tag, "_pol2"}, 32'(bus.dp_pol_2), 32'd0);
    endtask

    // One operation from the start request; entered and left at posedge+1.
    // delay >= 0 : exact timing expected with that many stall cycles.
    // rst_cyc > 0: reset is asserted in that cycle instead of finishing.
    task automatic run_op(input logic [2:0] opc, input int stall_pct, input int st_lo,
                          input int st_hi, input int rst_cyc, input int delay, input string tag);
        int  cyc, prog, exp_done, n_rd, n_wr, first_wr, last_wr, hazard, done_cyc;
        bit  fin;
        prog = 0; exp_done = -1; n_rd = 0; n_wr = 0; first_wr = -1; last_wr = -1;
        hazard = 0; done_cyc = -1; fin = 1'b0;
        bus.start = 1'b1; bus.op = opc; bus.stall = 1'b0;
        @(posedge clk); #1;
        cyc = 1;
        while (!fin && cyc < 3 * int'(N)) begin
            bus.start = 1'($urandom_range(1));
            bus.op    = 3'($urandom);
            bus.stall = ((cyc >= st_lo) && (cyc <= st_hi)) || (int'($urandom_range(99)) < stall_pct);
            if (cyc == rst_cyc) rst = 1'b1;
            // done comes once N+2 unstalled cycles have elapsed
            if (prog == int'(N) + 2 && exp_done < 0) exp_done = cyc;
            #1;
            if (cyc == 1) err_c1 = bus.err;
            if (bus.rd_en) begin
                check_eq({tag, "_rd_addr"}, 32'(bus.rd_addr), n_rd);
                n_rd++;
            end
            if (bus.wr_en) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (n_wr < int'(N)) begin
                    check_eq({tag, "_wr_addr"}, 32'(bus.wr_addr), n_wr);
                    check_eq({tag, "_wr_data"}, 32'(bus.wr_data),
                             ref_coef(opc, int'(mem_a[n_wr]), int'(mem_b[n_wr])));
                end else begin
                    check_eq({tag, "_wr_extra"}, n_wr + 1, N);
                end
                n_wr++;
            end
            if (bus.stall && (bus.rd_en || bus.wr_en)) hazard++;
            if (bus.reject || !bus.busy) hazard++;
            if (bus.done) begin
                done_cyc = cyc;
                last_err_done = bus.err;
                fin = 1'b1;
            end
            if (!bus.stall) prog++;
            if (cyc == rst_cyc) fin = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        if (rst_cyc > 0) begin
            rst = 1'b0; bus.start = 1'b0; bus.stall = 1'b0;
            #1;
            check_all_zero({tag, "_after_rst"});
            check_eq({tag, "_wr_before_rst"}, n_wr, rst_cyc - 2);
            repeat (5) begin
                @(posedge clk); #2;
                if (bus.done || bus.wr_en || bus.rd_en || bus.busy) hazard++;
            end
            check_eq({tag, "_hazards"}, hazard, 0);
            @(posedge clk); #1;
            return;
        end
        bus.start = 1'b0;
        bus.stall = 1'($urandom_range(1));
        #1;
        last_err_post = bus.err;
        check_eq({tag, "_idle_after"}, 32'({bus.busy, bus.done, bus.rd_en, bus.reject}), 32'd0);
        check_eq({tag, "_done_cyc"}, done_cyc, exp_done);
        check_eq({tag, "_n_rd"}, n_rd, N);
        check_eq({tag, "_n_wr"}, n_wr, N);
        check_eq({tag, "_hazards"}, hazard, 0);
        if (delay >= 0) begin
            check_eq({tag, "_first_wr"}, first_wr, 3);
            check_eq({tag, "_last_wr"}, last_wr, int'(N) + 2 + delay);
            check_eq({tag, "_done_abs"}, done_cyc, int'(N) + 3 + delay);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.op = 3'b000; bus.stall = 1'b0;
        last_err_done = 1'b0; last_err_post = 1'b0; err_c1 = 1'b0;
        fill_mem(1'b0);
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // op[2]=0 request is refused without starting
        bus.start = 1'b1; bus.op = 3'b011;
        @(posedge clk); #1;
        bus.start = 1'b0;
        #1;
        check_eq("rej_pulse", 32'(bus.reject), 32'd1);
        check_eq("rej_idle", 32'({bus.busy, bus.rd_en}), 32'd0);
        @(posedge clk); #2;
        check_eq("rej_once", 32'({bus.reject, bus.busy, bus.rd_en}), 32'd0);
        @(posedge clk); #1;

        run_op(3'b100, 0, 0, -1, 0, 0, "add_const");

        fill_mem(1'b1);
        mem_a[0] = 16'd5; mem_b[0] = 16'd3; mem_a[1] = 16'd3; mem_b[1] = 16'd5;
        run_op(3'b111, 0, 0, -1, 0, 0, "sub_rand");

        fill_mem(1'b0);
        run_op(3'b100, 0, 10, 14, 0, 5, "stall_win");

        fill_mem(1'b1);
        run_op(3'b101, 0, 0, -1, 100, -1, "rst_mid");
        run_op(3'b101, 0, 0, -1, 0, 0, "after_rst");

        run_op(3'b110, 20, 0, -1, 0, -1, "rand_stall");

        fill_mem(1'b1);
        mem_a[37] = 16'd7681;
        run_op(3'b111, 10, 0, -1, 0, -1, "range");
`ifdef POL_ADD_SUB_CTRL_CHECK_EN
        check_eq("err_at_done", 32'(last_err_done), 32'd1);
        check_eq("err_sticky", 32'(last_err_post), 32'd1);
`else
        check_eq("err_tied_done", 32'(last_err_done), 32'd0);
        check_eq("err_tied_post", 32'(last_err_post), 32'd0);
`endif
        fill_mem(1'b1);
        run_op(3'b100, 0, 0, -1, 0, 0, "clean");
        check_eq("err_cleared", 32'(err_c1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
